// File: rtl/ram_mm_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port RAM slave.
interface ram_mm_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 32
);
  logic            ra_req, ra_we, ra_ack, ra_rvalid;
  logic [AW-1:0]   ra_addr;
  logic [DW-1:0]   ra_wdata, ra_rdata;
  logic [DW/8-1:0] ra_be;

  logic            rb_req, rb_we, rb_ack, rb_rvalid;
  logic [AW-1:0]   rb_addr;
  logic [DW-1:0]   rb_wdata, rb_rdata;
  logic [DW/8-1:0] rb_be;

  logic            clr_start, clr_busy;

  logic [AW-1:0]   ram_address;
  logic            ram_chipselect, ram_clken, ram_write;
  logic [DW-1:0]   ram_writedata, ram_readdata;
  logic [DW/8-1:0] ram_byteenable;

  // arbiter side
  modport slave (
    input  ra_req, ra_we, ra_addr, ra_wdata, ra_be,
    output ra_ack, ra_rvalid, ra_rdata,
    input  rb_req, rb_we, rb_addr, rb_wdata, rb_be,
    output rb_ack, rb_rvalid, rb_rdata,
    input  clr_start,
    output clr_busy,
    output ram_address, ram_chipselect, ram_clken, ram_write,
    output ram_writedata, ram_byteenable,
    input  ram_readdata
  );

  // requesters + RAM side
  modport master (
    output ra_req, ra_we, ra_addr, ra_wdata, ra_be,
    input  ra_ack, ra_rvalid, ra_rdata,
    output rb_req, rb_we, rb_addr, rb_wdata, rb_be,
    input  rb_ack, rb_rvalid, rb_rdata,
    output clr_start,
    input  clr_busy,
    input  ram_address, ram_chipselect, ram_clken, ram_write,
    input  ram_writedata, ram_byteenable,
    output ram_readdata
  );
endinterface

// File: rtl/ram_mm_arbiter.sv
// Two-requester round-robin arbiter onto one RAM port, with a zero-fill sweep.
module ram_mm_arbiter #(
  parameter int AW           = 13,
  parameter int DW           = 32,
  parameter int READ_LATENCY = 1,
  parameter int CLR_WORDS    = 8192
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  ram_mm_arbiter_if.slave     bus
);
  localparam int            BW      = DW/8;
  localparam logic [AW:0]   CLR_END = (AW+1)'(CLR_WORDS);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t          state, state_nxt;
  logic [AW:0]     clr_cnt;       // next sweep address; one extra bit so 2^AW fits
  logic            last_b;        // last grant went to b
  logic            gnt_a, gnt_b;

  logic            cs_q, we_q, id_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wd_q;
  logic [BW-1:0]   be_q;

  logic [READ_LATENCY:1] vld_pipe, id_pipe;
  logic            rd_issue;
  logic            rv_a, rv_b;
  logic [DW-1:0]   rd_a, rd_b;

  // state register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= ARB;
    else             state <= state_nxt;
  end

  // next state: a sweep starts on clr_start and ends once every word is issued
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (bus.clr_start)     state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == CLR_END) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // grant: only in ARB, clear beats requests, ties go to the one not served last
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state == ARB && !bus.clr_start && !reset_reset) begin
      if (bus.ra_req && (!bus.rb_req || last_b)) gnt_a = 1'b1;
      else if (bus.rb_req)                       gnt_b = 1'b1;
    end
  end

  assign bus.ra_ack    = gnt_a;
  assign bus.rb_ack    = gnt_b;
  assign bus.clr_busy  = (state == CLEAR);
  assign bus.ram_clken = ~reset_reset;

  // round-robin pointer and sweep address counter
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      last_b  <= 1'b1;
      clr_cnt <= '0;
    end else begin
      if (gnt_a)      last_b <= 1'b0;
      else if (gnt_b) last_b <= 1'b1;
      if (state == ARB && bus.clr_start) clr_cnt <= (AW+1)'(1);
      else if (state == CLEAR)           clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // registered RAM command: granted request, or sweep word 0 on entry, then 1..N-1
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cs_q <= 1'b0; we_q <= 1'b0; id_q <= 1'b0;
      addr_q <= '0; wd_q <= '0;   be_q <= '0;
    end else begin
      cs_q <= 1'b0;
      we_q <= 1'b0;
      if (gnt_a || gnt_b) begin
        cs_q   <= 1'b1;
        id_q   <= gnt_b;
        we_q   <= gnt_b ? bus.rb_we    : bus.ra_we;
        addr_q <= gnt_b ? bus.rb_addr  : bus.ra_addr;
        wd_q   <= gnt_b ? bus.rb_wdata : bus.ra_wdata;
        be_q   <= gnt_b ? bus.rb_be    : bus.ra_be;
      end else if (state == ARB && bus.clr_start) begin
        cs_q <= 1'b1; we_q <= 1'b1;
        addr_q <= '0; wd_q <= '0; be_q <= '1;
      end else if (state == CLEAR && clr_cnt < CLR_END) begin
        cs_q <= 1'b1; we_q <= 1'b1;
        addr_q <= clr_cnt[AW-1:0]; wd_q <= '0; be_q <= '1;
      end
    end
  end

  assign bus.ram_chipselect = cs_q;
  assign bus.ram_write      = we_q;
  assign bus.ram_address    = addr_q;
  assign bus.ram_writedata  = wd_q;
  assign bus.ram_byteenable = be_q;
  assign rd_issue           = cs_q & ~we_q;

  // read tracking: last stage lines up with the cycle readdata is valid
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= rd_issue;
      id_pipe[1]  <= id_q;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  // read return: capture readdata for the issuing requester only, hold otherwise
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rv_a <= 1'b0; rv_b <= 1'b0;
      rd_a <= '0;   rd_b <= '0;
    end else begin
      rv_a <= vld_pipe[READ_LATENCY] & ~id_pipe[READ_LATENCY];
      rv_b <= vld_pipe[READ_LATENCY] &  id_pipe[READ_LATENCY];
      if (vld_pipe[READ_LATENCY] && !id_pipe[READ_LATENCY]) rd_a <= bus.ram_readdata;
      if (vld_pipe[READ_LATENCY] &&  id_pipe[READ_LATENCY]) rd_b <= bus.ram_readdata;
    end
  end

  assign bus.ra_rvalid = rv_a;
  assign bus.rb_rvalid = rv_b;
  assign bus.ra_rdata  = rd_a;
  assign bus.rb_rdata  = rd_b;
endmodule

// File: doc/ram_mm_arbiter.md
RAM_MM_ARBITER -- requirements
Module: ram_mm_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 13, RAM word-address width.
REQ-002 Parameters SHALL be: DW, 32, data width; byte-enable width DW/8.
REQ-003 Parameters SHALL be: READ_LATENCY, 1, RAM readdata delay in cycles after the command cycle (1..4).
REQ-004 Parameters SHALL be: CLR_WORDS, 8192, words zeroed by a clear sweep (1..2^AW).
REQ-005 Single clock domain; reset synchronous, active-high.
REQ-006 Ports SHALL be as follows.
- clk_clk  in  1  clock.
- reset_reset  in  1  synchronous active-high reset.
- Per requester X in {a,b}:
  - rX_req  in  1  command request; held stable until rX_ack.
  - rX_we  in  1  1=write, 0=read.
  - rX_addr  in  AW  word address.
  - rX_wdata  in  DW  write data.
  - rX_be  in  DW/8  byte enables.
  - rX_ack  out  1  command accepted, 1-cycle pulse.
  - rX_rvalid  out  1  read data valid, 1-cycle pulse.
  - rX_rdata  out  DW  read data, registered.
- clr_start  in  1  start zero-fill sweep.
- clr_busy  out  1  sweep in progress.
- ram_address  out  AW  to RAM slave.
- ram_chipselect  out  1  to RAM slave.
- ram_clken  out  1  to RAM slave.
- ram_write  out  1  to RAM slave.
- ram_writedata  out  DW  to RAM slave.
- ram_byteenable  out  DW/8  to RAM slave.
- ram_readdata  in  DW  from RAM slave.

Function
REQ-007 States: ARB, CLEAR; reset state ARB.
REQ-008 ARB, cycle N:
- Requests present: exactly one rX_ack pulses combinationally in N.
- Command registered onto RAM port in N+1: chipselect=1; write=rX_we; address, writedata and byteenable copied.
REQ-009 Round-robin:
- Only one requester active: that requester wins.
- Both active: the requester not granted last wins.
- Last-grant pointer updates only on an ack; reset value = b, so a wins first.
REQ-010 At most one command per cycle; back-to-back acks allowed every cycle (full throughput).
REQ-011 ram_chipselect=0 and ram_write=0 in any cycle without an issued command; ram_clken=1 whenever reset_reset=0.
REQ-012 Read issued in cycle N+1:
- ram_readdata sampled at end of cycle N+1+READ_LATENCY.
- rX_rdata updated and rX_rvalid pulses in cycle N+2+READ_LATENCY, for the requester that issued the read only.
- Tracking uses a READ_LATENCY-deep (valid,id) pipeline; writes never produce rvalid.
REQ-013 rX_rdata holds its value between rvalid pulses.
REQ-014 clr_start sampled in ARB at cycle C:
- State becomes CLEAR in C+1; no acks in C (clear wins over simultaneous requests).
- Zero writes to addresses 0..CLR_WORDS-1, one per cycle, in cycles C+1..C+CLR_WORDS; byteenable all ones; writedata 0.
REQ-015 clr_busy=1 in C+1..C+CLR_WORDS; return to ARB in C+CLR_WORDS+1, where acks are again possible.
REQ-016 clr_start is ignored while in CLEAR; no acks while in CLEAR; requests stay pending.
REQ-017 Reads issued before a clear still return rvalid at their scheduled cycles during CLEAR.
REQ-018 Clear address counter is AW+1 bits wide; no wrap; the sweep ends exactly at CLR_WORDS-1.

Reset
REQ-019 On reset_reset=1 at a clock edge, the following SHALL take effect in the next cycle:
- State ARB; sweep aborted; clr_busy=0.
- All rX_ack/rX_rvalid=0; rX_rdata=0.
- ram_chipselect=0, ram_write=0, ram_address=0, ram_writedata=0, ram_byteenable=0.
- Read pipeline flushed, so in-flight reads never return rvalid.
- RR pointer=b; ram_clken=0 while reset asserted.

Verification
REQ-020 Single read, READ_LATENCY=1: ra_req, ra_we=0, ra_addr=0x005 at cycle 0 -> ra_ack cycle 0; chipselect=1, write=0, address=0x005 cycle 1; ra_rvalid cycle 3 with ra_rdata=model word.
REQ-021 Contention: ra_req and rb_req held continuously after reset -> acks alternate a,b,a,b; one command on RAM every cycle.
REQ-022 Write then read: rb writes 0xDEADBEEF with be=4'b0011 to 0x1FFF, then reads 0x1FFF -> rb_rdata=0x0000BEEF over previously-zero memory.
REQ-023 Clear: CLR_WORDS=16, clr_start and ra_req in cycle C -> no ack in C; 16 zero writes to addresses 0..15 in C+1..C+16; clr_busy high C+1..C+16; ra_ack in C+17.
REQ-024 Reset mid-clear: reset_reset high at write 5 of 16 -> next cycle chipselect=0 and clr_busy=0; addresses 6..15 retain prior data.
REQ-025 Reset with read in flight: read acked, reset asserted next cycle -> no ra_rvalid ever for that read.
